ahb_gpio_sequencer: RTL and testbench
=====================================

AHB_GPIO_SEQUENCER -- requirements
Module: ahb_gpio_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: number of pattern entries (power of 2, 2..8).
REQ-002 Parameter PERIOD_W, default 16: width of the step-period counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port HCLK, input, 1: sole clock, rising edge.
REQ-005 Port HRESET, input, 1: asynchronous, active-high reset.
REQ-006 Ports HSEL, HREADY, HWRITE (1), HTRANS (2), HSIZE (3), HADDR (32), HWDATA (32), all inputs: AHB-Lite slave inputs.
REQ-007 Port HRDATA, output, 32: read data.
REQ-008 Port HREADYOUT, output, 1: slave ready.
REQ-009 Port gpio_out, output, 16: sequenced pattern.
REQ-010 Port gpio_oeb, output, 16: output enables, active low.
REQ-011 Port irq, output, 1: level interrupt.

Function
REQ-012 Zero-wait slave; HREADYOUT SHALL be constant 1; HSIZE ignored, all accesses treated as full-word.
REQ-013 Address phase SHALL be accepted when HSEL & HREADY & HTRANS[1]; HADDR[7:2] and HWRITE registered.
REQ-014 Write data SHALL be taken from HWDATA in the following data phase; HRDATA SHALL be valid in the data phase; unmapped offsets read 0, writes ignored.
REQ-015 Register map, offset from HADDR[7:0]:
- 0x00 CTRL: [0] EN, [1] LOOP, [2] IRQ_EN.
- 0x04 STATUS, read-only except DONE: [0] BUSY, [1] DONE (write 1 to clear), [6:4] IDX.
- 0x08 PERIOD[PERIOD_W-1:0].
- 0x0C LEN[2:0]; entries used = LEN+1, writes masked to DEPTH-1.
- 0x10 OEB[15:0].
- 0x20+4*i PAT[i][15:0], i < DEPTH.
REQ-016 FSM states SHALL be IDLE and RUN; BUSY = (state==RUN).
REQ-017 IDLE->RUN on the cycle after a CTRL write with EN=1; on that edge idx=0, cnt=0, gpio_out<=PAT[0].
REQ-018 In RUN, cnt SHALL increment every cycle; a step ends when cnt >= PERIOD, so one step lasts PERIOD+1 cycles.
REQ-019 At step end with idx != LEN: idx<=idx+1, cnt<=0, gpio_out<=PAT[idx+1] on the same edge.
REQ-020 At step end with idx==LEN and LOOP=1: idx<=0, gpio_out<=PAT[0]; the block stays in RUN.
REQ-021 At step end with idx==LEN and LOOP=0: go to IDLE, EN<=0, DONE<=1; gpio_out holds its last value.
REQ-022 A CTRL write with EN=0 in RUN SHALL return to IDLE on the next edge; gpio_out holds and DONE is not set.
REQ-023 A CTRL write with EN=1 in RUN SHALL restart from entry 0 per REQ-017.
REQ-024 PAT, PERIOD and LEN writes during RUN take effect immediately; a changed PAT entry is used the next time it is loaded; the >= compare prevents counter overrun.
REQ-025 If a DONE set and a DONE W1C fall in the same cycle, the set SHALL win.
REQ-026 irq SHALL equal DONE & IRQ_EN, registered-free.
REQ-027 gpio_oeb SHALL equal the OEB register.

Reset
REQ-028 HRESET SHALL asynchronously force the following:
- state IDLE; CTRL, STATUS, PERIOD, LEN, cnt and idx to 0.
- all PAT entries 0; gpio_out 0.
- OEB 16'hFFFF (all outputs disabled).
- irq 0; HRDATA 0.
REQ-029 Reset asserted mid-sequence SHALL abort it; after release the block stays IDLE until EN is written.

Verification
REQ-030 PAT0..3 = 1,2,4,8, LEN=3, PERIOD=2, EN=1 -> gpio_out 1,2,4,8 each for 3 cycles; then DONE=1, BUSY=0, gpio_out stays 8.
REQ-031 Same setup with LOOP=1 -> sequence repeats 1,2,4,8,1 with no gap; DONE stays 0.
REQ-032 IRQ_EN=1 and run to completion -> irq=1; write STATUS=0x2 -> irq=0 next cycle; W1C coinciding with completion -> DONE remains 1.
REQ-033 Write EN=0 mid-step -> BUSY=0 next cycle, gpio_out frozen, DONE=0.
REQ-034 Assert HRESET mid-run -> gpio_out=0, gpio_oeb=16'hFFFF, STATUS=0 immediately; read of 0x44 -> 0.
REQ-035 Back-to-back write PERIOD=5 then read PERIOD -> 5 with HREADYOUT=1 throughout.

Source files
------------

// File: rtl/ahb_gpio_sequencer.sv
// ahb_gpio_sequencer
//   AHB-Lite zero-wait slave that steps a 16-bit GPIO output through a small
//   table of patterns. Each table entry is held for PERIOD+1 clock cycles.
//   A run either wraps back to entry 0 (LOOP) or stops and raises DONE.
//
// Ports
//   HCLK, HRESET        clock (rising edge) and asynchronous active-high reset
//   HSEL .. HWDATA      AHB-Lite slave inputs (HSIZE is ignored)
//   HRDATA, HREADYOUT   read data (valid in the data phase) and ready (always 1)
//   gpio_out            current pattern entry
//   gpio_oeb            output enables, active low (OEB register)
//   irq                 level interrupt, DONE & IRQ_EN
//
// Register map (byte offsets, HADDR[7:0])
//   0x00 CTRL   [0] EN  [1] LOOP  [2] IRQ_EN
//   0x04 STATUS [0] BUSY  [1] DONE (W1C)  [6:4] IDX
//   0x08 PERIOD
//   0x0C LEN    (entries used = LEN+1)
//   0x10 OEB
//   0x20+4*i PAT[i]
//
// Bus handshake: an address phase is taken when HSEL & HREADY & HTRANS[1].
// Its offset and direction are registered, and the access completes in the
// next cycle. Write data is committed on the edge that ends the data phase.
// Read data is driven combinationally during the data phase. HREADYOUT never
// stalls the bus.
module ahb_gpio_sequencer #(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [15:0] gpio_out,
  output logic [15:0] gpio_oeb,
  output logic        irq
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                dp_valid_q, dp_write_q;
  logic [5:0]          dp_addr_q;
  logic                ctrl_en_q, ctrl_loop_q, ctrl_irq_en_q, done_q;
  logic [PERIOD_W-1:0] period_q, cnt_q;
  logic [IW-1:0]       len_q, idx_q;
  logic [15:0]         oeb_q, gpio_q;
  logic [15:0]         pat_q [DEPTH];

  logic                wr, rd, wr_ctrl, wr_status, wr_period, wr_len, wr_oeb, wr_pat;
  logic                pat_hit, step_end;
  logic [IW-1:0]       pat_sel;
  logic                start, seq_adv, seq_wrap, seq_finish;
  logic [31:0]         rdata;
  logic                unused_ok;

  assign unused_ok = ^{HSIZE, HADDR[31:8], HADDR[1:0], HTRANS[0], HWDATA};

  // ---------------------------------------------------------------- bus phases
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
    end else begin
      dp_valid_q <= HSEL & HREADY & HTRANS[1];
      if (HSEL & HREADY & HTRANS[1]) begin
        dp_write_q <= HWRITE;
        dp_addr_q  <= HADDR[7:2];
      end
    end
  end

  assign wr        = dp_valid_q & dp_write_q;
  assign rd        = dp_valid_q & ~dp_write_q;
  assign pat_hit   = (dp_addr_q[5:3] == 3'b001) && (int'(dp_addr_q[2:0]) < DEPTH);
  assign pat_sel   = dp_addr_q[IW-1:0];
  assign wr_ctrl   = wr && (dp_addr_q == 6'h00);
  assign wr_status = wr && (dp_addr_q == 6'h01);
  assign wr_period = wr && (dp_addr_q == 6'h02);
  assign wr_len    = wr && (dp_addr_q == 6'h03);
  assign wr_oeb    = wr && (dp_addr_q == 6'h04);
  assign wr_pat    = wr && pat_hit;

  // >= rather than == so that lowering PERIOD mid-step ends the step at once
  assign step_end  = (cnt_q >= period_q);

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A CTRL write overrides sequencing: EN=1 (re)starts from entry 0 and
  // EN=0 stops, with gpio_out held and DONE untouched.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    seq_adv    = 1'b0;
    seq_wrap   = 1'b0;
    seq_finish = 1'b0;
    if (wr_ctrl) begin
      if (HWDATA[0]) begin
        state_d = RUN;
        start   = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == RUN && step_end) begin
      if (idx_q != len_q) begin
        seq_adv = 1'b1;
      end else if (ctrl_loop_q) begin
        seq_wrap = 1'b1;
      end else begin
        seq_finish = 1'b1;
        state_d    = IDLE;
      end
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl_en_q     <= 1'b0;
      ctrl_loop_q   <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      done_q        <= 1'b0;
      period_q      <= '0;
      len_q         <= '0;
      oeb_q         <= 16'hFFFF;
    end else begin
      if (wr_ctrl) begin
        ctrl_en_q     <= HWDATA[0];
        ctrl_loop_q   <= HWDATA[1];
        ctrl_irq_en_q <= HWDATA[2];
      end else if (seq_finish) begin
        ctrl_en_q <= 1'b0;
      end
      // completion takes priority over a simultaneous W1C
      if (seq_finish)                 done_q <= 1'b1;
      else if (wr_status && HWDATA[1]) done_q <= 1'b0;
      if (wr_period) period_q <= HWDATA[PERIOD_W-1:0];
      // keeping only IW bits masks LEN to DEPTH-1
      if (wr_len)    len_q    <= HWDATA[IW-1:0];
      if (wr_oeb)    oeb_q    <= HWDATA[15:0];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
    end else if (wr_pat) begin
      pat_q[pat_sel] <= HWDATA[15:0];
    end
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      gpio_q <= '0;
    end else begin
      if (start)                cnt_q <= '0;
      else if (state_q == RUN)  cnt_q <= step_end ? '0 : cnt_q + 1'b1;

      if (start || seq_wrap) begin
        idx_q  <= '0;
        gpio_q <= pat_q[0];
      end else if (seq_adv) begin
        idx_q  <= idx_q + 1'b1;
        gpio_q <= pat_q[idx_q + 1'b1];
      end
    end
  end

  // ------------------------------------------------------------- read mux
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (dp_addr_q)
        6'h00:   rdata = {29'd0, ctrl_irq_en_q, ctrl_loop_q, ctrl_en_q};
        6'h01:   rdata = {25'd0, 3'(idx_q), 2'b00, done_q, (state_q == RUN)};
        6'h02:   rdata = 32'(period_q);
        6'h03:   rdata = 32'(len_q);
        6'h04:   rdata = {16'd0, oeb_q};
        default: if (pat_hit) rdata = {16'd0, pat_q[pat_sel]};
      endcase
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign gpio_out  = gpio_q;
  assign gpio_oeb  = oeb_q;
  assign irq       = done_q & ctrl_irq_en_q;

endmodule

// File: tb/tb_ahb_gpio_sequencer.sv
// Testbench for ahb_gpio_sequencer. The reference model predicts gpio_out
// from elapsed cycles since start: entry = k / (PERIOD+1), clamped to LEN
// for one-shot runs or taken modulo LEN+1 for looping runs.
module tb_ahb_gpio_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL, HREADY, HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR, HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [15:0] gpio_out, gpio_oeb;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [15:0] mdl_pat [8];
  int          mdl_period;
  int          mdl_len;
  bit          mdl_loop;
  bit          mdl_irq_en;

  ahb_gpio_sequencer #(.DEPTH(8), .PERIOD_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .irq(irq)
  );

  // ------------------------------------------------------- clock / reset
  always #5 HCLK = ~HCLK;

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------- driver tasks
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'd0, a};
    next_cycle();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
    next_cycle();
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'd0, a};
    next_cycle();
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    next_cycle();
  endtask

  // ------------------------------------------------------ reference model
  function automatic logic [15:0] model_gpio(input int k);
    int step;
    step = k / (mdl_period + 1);
    if (mdl_loop) step = step % (mdl_len + 1);
    else if (step > mdl_len) step = mdl_len;
    return mdl_pat[step];
  endfunction

  function automatic logic model_irq(input int k);
    return mdl_irq_en && !mdl_loop && (k >= (mdl_len + 1) * (mdl_period + 1));
  endfunction

  // Stops any run, clears DONE, loads the model's table, then starts.
  // Returns in the first RUN cycle (k = 0).
  task automatic start_seq(input logic [2:0] ctrl, input int period, input int len);
    bus_write(8'h00, 32'd0);
    bus_write(8'h04, 32'h2);
    for (int i = 0; i < 8; i++) bus_write(8'h20 + 8'(4 * i), {16'd0, mdl_pat[i]});
    bus_write(8'h08, period);
    bus_write(8'h0C, len);
    mdl_period = period;
    mdl_len    = len;
    mdl_loop   = ctrl[1];
    mdl_irq_en = ctrl[2];
    bus_write(8'h00, {29'd0, ctrl});
  endtask

  task automatic run_check(input string tag, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      chk({tag, "_gpio"}, {16'd0, gpio_out}, {16'd0, model_gpio(k)});
      chk({tag, "_irq"}, {31'd0, irq}, {31'd0, model_irq(k)});
      next_cycle();
    end
  endtask

  // ----------------------------------------------------------- stimulus
  logic [31:0] rv;
  int          t_total;
  logic [15:0] frozen;

  initial begin
    HRESET = 1'b1;
    HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0; HTRANS = 2'b00;
    HSIZE = 3'b010; HADDR = '0; HWDATA = '0;
    repeat (3) next_cycle();

    // reset state
    chk("rst_gpio", {16'd0, gpio_out}, 32'h0);
    chk("rst_oeb", {16'd0, gpio_oeb}, 32'hFFFF);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'h1);
    HRESET = 1'b0;
    next_cycle();
    bus_read(8'h00, rv); chk("rst_ctrl", rv, 32'h0);
    bus_read(8'h04, rv); chk("rst_status", rv, 32'h0);
    bus_read(8'h08, rv); chk("rst_period", rv, 32'h0);
    bus_read(8'h0C, rv); chk("rst_len", rv, 32'h0);
    bus_read(8'h10, rv); chk("rst_oeb_reg", rv, 32'hFFFF);
    bus_read(8'h3C, rv); chk("rst_pat7", rv, 32'h0);

    // register behaviour: LEN masking, unmapped offsets, OEB output
    bus_write(8'h0C, 32'hF);     bus_read(8'h0C, rv); chk("len_mask", rv, 32'h7);
    bus_write(8'h44, 32'h1234);  bus_read(8'h44, rv); chk("unmapped", rv, 32'h0);
    bus_write(8'h10, 32'h00F0);  chk("oeb_out", {16'd0, gpio_oeb}, 32'h00F0);
    bus_write(8'h24, 32'hABCD);  bus_read(8'h24, rv); chk("pat1_rw", rv, 32'hABCD);

    // one-shot 1,2,4,8 with PERIOD=2
    for (int i = 0; i < 8; i++) mdl_pat[i] = 16'h0;
    mdl_pat[0] = 16'h1; mdl_pat[1] = 16'h2; mdl_pat[2] = 16'h4; mdl_pat[3] = 16'h8;
    start_seq(3'b001, 2, 3);
    run_check("oneshot", 15);
    chk("oneshot_hold", {16'd0, gpio_out}, 32'h8);
    bus_read(8'h04, rv); chk("oneshot_status", rv & 32'h3, 32'h2);
    bus_read(8'h00, rv); chk("oneshot_en_clr", rv, 32'h0);

    // looping run: no gap, DONE stays clear
    start_seq(3'b011, 2, 3);
    run_check("loop", 30);
    bus_read(8'h04, rv); chk("loop_status", rv & 32'h3, 32'h1);

    // IRQ at completion and W1C
    start_seq(3'b101, 2, 3);
    t_total = 12;
    run_check("irq", t_total + 2);
    bus_write(8'h04, 32'h2);
    chk("irq_w1c", {31'd0, irq}, 32'h0);

    // W1C landing on the completion edge: DONE must survive
    start_seq(3'b101, 2, 3);
    repeat (t_total - 2) next_cycle();
    bus_write(8'h04, 32'h2);
    chk("w1c_race_irq", {31'd0, irq}, 32'h1);
    bus_read(8'h04, rv); chk("w1c_race_done", rv & 32'h3, 32'h2);

    // EN=0 mid-step: write issued at k=4 commits after cycle k=5
    start_seq(3'b001, 2, 3);
    repeat (4) next_cycle();
    frozen = model_gpio(5);
    bus_write(8'h00, 32'h0);
    chk("stop_gpio", {16'd0, gpio_out}, {16'd0, frozen});
    bus_read(8'h04, rv); chk("stop_status", rv & 32'h3, 32'h0);
    repeat (4) next_cycle();
    chk("stop_frozen", {16'd0, gpio_out}, {16'd0, frozen});

    // back-to-back write then read of PERIOD
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h08;
    next_cycle();
    chk("b2b_ready0", {31'd0, HREADYOUT}, 32'h1);
    HWDATA = 32'd5; HWRITE = 1'b0; HADDR = 32'h08;
    next_cycle();
    chk("b2b_ready1", {31'd0, HREADYOUT}, 32'h1);
    HSEL = 1'b0; HTRANS = 2'b00;
    chk("b2b_period", HRDATA, 32'd5);
    next_cycle();
    chk("b2b_ready2", {31'd0, HREADYOUT}, 32'h1);

    // randomized runs
    for (int it = 0; it < 8; it++) begin
      int p, l;
      logic [2:0] c;
      for (int i = 0; i < 8; i++) mdl_pat[i] = 16'($urandom_range(0, 16'hFFFF));
      p = $urandom_range(0, 3);
      l = $urandom_range(0, 7);
      c = {1'b1, 1'($urandom_range(0, 1)), 1'b1};
      start_seq(c, p, l);
      run_check("rand", (l + 1) * (p + 1) + 3);
    end

    // reset in the middle of a run
    bus_write(8'h10, 32'h0F0F);
    for (int i = 0; i < 8; i++) mdl_pat[i] = 16'h8000 >> i;
    start_seq(3'b111, 3, 7);
    repeat (5) next_cycle();
    HRESET = 1'b1;
    #1;
    chk("arst_gpio", {16'd0, gpio_out}, 32'h0);
    chk("arst_oeb", {16'd0, gpio_oeb}, 32'hFFFF);
    chk("arst_irq", {31'd0, irq}, 32'h0);
    next_cycle();
    HRESET = 1'b0;
    next_cycle();
    bus_read(8'h04, rv); chk("arst_status", rv, 32'h0);
    bus_read(8'h44, rv); chk("arst_unmapped", rv, 32'h0);
    repeat (6) next_cycle();
    chk("arst_idle_gpio", {16'd0, gpio_out}, 32'h0);
    bus_read(8'h04, rv); chk("arst_idle_status", rv, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time bound so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
